// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: byte width, default sizing
// and the drain state machine encoding.
package uart_pkg;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned DEFAULT_DEPTH       = 16;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags; the read data is
// the current head entry, consumed by the rd_en strobe.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_wr;
  logic             do_rd;

  // Gate strobes with the registered flags and derive next pointers/flags.
  always_comb begin
    do_wr    = wr_en & ~full_q;
    do_rd    = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Host-side byte queue that drains into a downstream UART transmitter using a
// start/busy handshake, with sticky overflow and acknowledge-timeout flags.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clear_err,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic                   ack_err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  drain_state_e      state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              overflow_q, overflow_d;
  logic              ack_err_q, ack_err_d;
  logic              pop_en;
  logic              ack_set;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_en),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Drain FSM next state; the pop happens on the IDLE->LAUNCH edge so
  // tx_start and tx_data both come straight from registers.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop_en     = 1'b0;
    ack_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop_en     = 1'b1;
          tx_data_d  = fifo_rdata;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          timer_d = '0;
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte rather than retry.
          ack_set = 1'b1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags; a set event in the same cycle beats clear_err.
  always_comb begin
    overflow_d = overflow_q;
    ack_err_d  = ack_err_q;
    if (wr_en && fifo_full) begin
      overflow_d = 1'b1;
    end else if (clear_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (ack_set) begin
      ack_err_d = 1'b1;
    end else if (clear_err) begin
      ack_err_d = 1'b0;
    end else begin
      ack_err_d = ack_err_q;
    end
  end

  // State, output and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;
  assign ack_err  = ack_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
